// File: rtl/scr1_imem_prefetch_pkg.sv
// Shared memory-interface types and constants for the instruction prefetch buffer.
package scr1_imem_prefetch_pkg;

  localparam int SCR1_IMEM_AWIDTH = 32;
  localparam int SCR1_IMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_IDLE   = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  // Clears the byte offset so every fetch is word aligned.
  function automatic logic [SCR1_IMEM_AWIDTH-1:0] scr1_word_align(
    input logic [SCR1_IMEM_AWIDTH-1:0] addr
  );
    return addr & {{(SCR1_IMEM_AWIDTH-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/scr1_imem_pf_fifo.sv
// Small synchronous FIFO holding fetched words together with their error flag.
module scr1_imem_pf_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push & ~clear;
  assign w_pop  = pop & ~clear & ~empty;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign count = r_count;
  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign head  = empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/scr1_imem_prefetch.sv
// Sequential instruction prefetcher: issues word reads after a redirect and buffers results.
module scr1_imem_prefetch
  import scr1_imem_prefetch_pkg::*;
#(
  parameter int SCR1_PF_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ifu_new_pc_req,
  input  logic [SCR1_IMEM_AWIDTH-1:0] ifu_new_pc,
  output logic                        ifu_instr_vd,
  output logic [SCR1_IMEM_DWIDTH-1:0] ifu_instr,
  output logic                        ifu_instr_err,
  input  logic                        ifu_instr_rdy,
  output logic                        imem_req,
  input  logic                        imem_req_ack,
  output type_scr1_mem_cmd_e          imem_cmd,
  output logic [SCR1_IMEM_AWIDTH-1:0] imem_addr,
  input  logic [SCR1_IMEM_DWIDTH-1:0] imem_rdata,
  input  type_scr1_mem_resp_e         imem_resp
);

  localparam int AW = SCR1_IMEM_AWIDTH;
  localparam int DW = SCR1_IMEM_DWIDTH;
  localparam int CW = $clog2(SCR1_PF_DEPTH) + 1;
  localparam logic [CW-1:0] BTB_LIMIT = CW'(SCR1_PF_DEPTH - 2);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_FLUSH,
    ST_ERR
  } pf_state_e;

  pf_state_e       r_state;
  pf_state_e       w_state_next;
  logic [AW-1:0]   r_fetch_addr;
  logic            w_req;
  logic            w_push;
  logic            w_push_err;
  logic            w_pop;
  logic            w_resp_ok;
  logic            w_resp_er;
  logic [DW:0]     w_push_data;
  logic [DW:0]     w_head;
  logic            w_full;
  logic            w_empty;
  logic [CW-1:0]   w_count;

  assign w_resp_ok = (imem_resp == SCR1_MEM_RESP_RDY_OK);
  assign w_resp_er = (imem_resp == SCR1_MEM_RESP_RDY_ER);

  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_push       = 1'b0;
    w_push_err   = 1'b0;
    if (ifu_new_pc_req) begin
      // A response still owed to the old stream must be swallowed before refetching.
      if ((r_state == ST_DATA || r_state == ST_FLUSH) && !w_resp_ok && !w_resp_er)
        w_state_next = ST_FLUSH;
      else
        w_state_next = ST_ADDR;
    end else begin
      case (r_state)
        ST_ADDR: begin
          w_req = ~w_full;
          if (w_req && imem_req_ack) w_state_next = ST_DATA;
        end
        ST_DATA: begin
          if (w_resp_ok) begin
            w_push = 1'b1;
            // Back-to-back only while one slot remains for the next response.
            w_req  = (w_count <= BTB_LIMIT);
            w_state_next = (w_req && imem_req_ack) ? ST_DATA : ST_ADDR;
          end else if (w_resp_er) begin
            w_push       = 1'b1;
            w_push_err   = 1'b1;
            w_state_next = ST_ERR;
          end
        end
        ST_FLUSH: begin
          if (w_resp_ok || w_resp_er) w_state_next = ST_ADDR;
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_fetch_addr <= '0;
    end else begin
      r_state <= w_state_next;
      if (ifu_new_pc_req)
        r_fetch_addr <= scr1_word_align(ifu_new_pc);
      else if (w_req && imem_req_ack)
        r_fetch_addr <= r_fetch_addr + AW'(4);
    end
  end

  assign w_push_data = {w_push_err, (w_push_err ? {DW{1'b0}} : imem_rdata)};
  assign w_pop       = ~w_empty & ifu_instr_rdy & ~ifu_new_pc_req;

  scr1_imem_pf_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (SCR1_PF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .clear     (ifu_new_pc_req),
    .push_data (w_push_data),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count),
    .head      (w_head)
  );

  assign imem_req      = w_req;
  assign imem_addr     = r_fetch_addr;
  assign imem_cmd      = SCR1_MEM_CMD_RD;
  assign ifu_instr_vd  = ~w_empty;
  assign ifu_instr_err = w_head[DW];
  assign ifu_instr     = w_head[DW-1:0];

endmodule

// File: doc/scr1_imem_prefetch.md
# scr1_imem_prefetch

Instruction prefetch buffer between the core fetch unit and the instruction memory router. After a redirect it issues sequential word-aligned read requests and accepts a new request in the same cycle a response arrives. Returned words go into a small FIFO, which the fetch unit drains through a valid/ready handshake. On a redirect the buffer flushes its contents and discards any response still in flight.

## Interface
- SCR1_PF_DEPTH, 4: FIFO entries; power of two, minimum 2.
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- ifu_new_pc_req  in  1  redirect strobe; has priority over every other event in the same cycle.
- ifu_new_pc  in  `SCR1_IMEM_AWIDTH  redirect target; bits [1:0] are ignored.
- ifu_instr_vd  out  1  head entry valid.
- ifu_instr  out  `SCR1_IMEM_DWIDTH  head data; 0 when the FIFO is empty.
- ifu_instr_err  out  1  head entry carries a fetch error; 0 when the FIFO is empty.
- ifu_instr_rdy  in  1  fetch unit accepts the head entry.
- imem_req  out  1  request to the router.
- imem_req_ack  in  1  router accepts the request.
- imem_cmd  out  type_scr1_mem_cmd_e  constant SCR1_MEM_CMD_RD.
- imem_addr  out  `SCR1_IMEM_AWIDTH  fetch address, bits [1:0] = 0.
- imem_rdata  in  `SCR1_IMEM_DWIDTH  read data.
- imem_resp  in  type_scr1_mem_resp_e  IDLE / RDY_OK / RDY_ER.

## Operation
- FSM states:
  - IDLE: reset state; no fetching.
  - ADDR: request phase, nothing outstanding.
  - DATA: one request outstanding.
  - FLUSH: outstanding response to be discarded.
  - ERR: fetch stopped after an error.
- Registers: fetch_addr (reset 0), FIFO count (reset 0), FIFO pointers (reset 0).
- imem_req:
  - Always 0 when ifu_new_pc_req = 1.
  - ADDR: 1 when count < DEPTH.
  - DATA: 1 only when imem_resp = RDY_OK and count <= DEPTH-2.
  - IDLE, FLUSH, ERR: 0.
- imem_req & imem_req_ack: fetch_addr += 4, modulo 2^AWIDTH (0xFFFFFFFC wraps to 0); next state DATA.
- DATA transitions:
  - RDY_OK: push {err=0, imem_rdata}. Next state DATA if a new request was accepted this cycle, else ADDR.
  - RDY_ER: push {err=1, data=0}; next state ERR.
  - IDLE: hold.
- ERR: no requests; the FIFO keeps draining; leave only by redirect.
- Redirect (any state):
  - FIFO is cleared; count is 0 next cycle.
  - fetch_addr <= {ifu_new_pc[AW-1:2], 2'b00}.
  - No push and no pop occur this cycle.
  - Next state FLUSH if the current state is DATA or FLUSH and imem_resp = IDLE; otherwise ADDR.
- FLUSH: the first non-IDLE response (OK or ER) is dropped without a push; next state ADDR.
- Pop when ifu_instr_vd & ifu_instr_rdy & ~ifu_new_pc_req.
- Push and pop in the same cycle is legal and leaves count unchanged.
- A push is never attempted while the FIFO is full; space is reserved by the request gating rules.
- ifu_instr_vd = (count != 0).

## Timing
- Reset values: imem_req=0, imem_addr=0, ifu_instr_vd=0, ifu_instr=0, ifu_instr_err=0, imem_cmd=RD.
- Redirect in cycle N: imem_req=1 in cycle N+1 with the new address.
- If acked in N+1 and responded in N+2, ifu_instr_vd=1 in N+3. Redirect-to-instruction latency is 3 cycles.
- With a zero-wait router, a steady state of one word per cycle is sustained when count stays <= DEPTH-2.
- All core-side outputs come directly from registers or the FIFO head. imem_req depends combinationally on imem_resp, as the router's back-to-back protocol requires.
- Reset mid-operation: return to IDLE and empty the FIFO. A response to a pre-reset request may still arrive; IDLE ignores it.

## Structure
- type_scr1_mem_cmd_e and type_scr1_mem_resp_e come from the shared memif header.
- The FSM enum (IDLE/ADDR/DATA/FLUSH/ERR) is local to the block.
- One sub-module, scr1_imem_pf_fifo:
  - Synchronous FIFO, width DWIDTH+1, depth SCR1_PF_DEPTH.
  - Ports: push, pop, clear, full, empty, count, head.

## Test plan
- Redirect to 0x0000_0102 with a zero-wait router returning rdata=addr: imem_addr sequence 0x100, 0x104, 0x108…; ifu_instr 0x100, 0x104 in consecutive cycles from N+3.
- ifu_instr_rdy=0: exactly DEPTH words stored and imem_req drops to 0. Set rdy=1: words drain in order with no gaps or duplicates.
- Redirect to 0x200 while one request to 0x104 is outstanding and its response arrives two cycles later: response dropped, FIFO empty, next delivered word is 0x200.
- Response RDY_ER at address 0x108: delivered with ifu_instr_err=1 and no further imem_req. A redirect to 0x300 resumes fetching at 0x300.
- Redirect to 0xFFFF_FFF8: imem_addr sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- rst asserted while in DATA with 3 words buffered: next cycle ifu_instr_vd=0, imem_req=0, and a late RDY_OK response is ignored.
